// File: rtl/fixed_tile_absmax_quantizer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : fixed_tile_absmax_quantizer                                        |
// | Brief  : Buffers a tile of IN_DEPTH fixed-point beats, tracks the tile's    |
// |          absolute maximum and re-emits the tile as OUT_WIDTH signed ints    |
// |          scaled by a power of two (round half up, symmetric saturation).    |
// |          Define TILE_QUANT_DOUBLE_BUF_EN for two ping-pong banks so that    |
// |          collection and emission overlap (1 beat/clk sustained).            |
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
module fixed_tile_absmax_quantizer #(
  parameter int IN_WIDTH       = 16,
  parameter int IN_SIZE        = 1,
  parameter int IN_PARALLELISM = 4,
  parameter int IN_DEPTH       = 3,
  parameter int OUT_WIDTH      = 8
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic [IN_WIDTH*IN_PARALLELISM*IN_SIZE-1:0]         data_in,
  input  logic                                               data_in_valid,
  output logic                                               data_in_ready,
  output logic [OUT_WIDTH*IN_PARALLELISM*IN_SIZE-1:0]        data_out,
  output logic                                               data_out_valid,
  input  logic                                               data_out_ready,
  output logic                                               data_out_last,
  output logic [IN_WIDTH-1:0]                                max_num,
  output logic signed [$clog2(IN_WIDTH):0]                   scale_shift
);

  localparam int N       = IN_PARALLELISM * IN_SIZE;
  localparam int SHIFT_W = $clog2(IN_WIDTH) + 1;
  localparam int CNT_W   = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam logic [CNT_W-1:0]        LAST_IDX = CNT_W'(IN_DEPTH - 1);
  localparam logic signed [IN_WIDTH:0] QMAX     = (IN_WIDTH+1)'((2**(OUT_WIDTH-1)) - 1);
  localparam logic signed [IN_WIDTH:0] QMIN     = -QMAX;
  localparam logic signed [IN_WIDTH:0] WIDE_ONE = (IN_WIDTH+1)'(1);

`ifdef TILE_QUANT_DOUBLE_BUF_EN
  localparam logic DBL = 1'b1;  // bank pointers toggle between two banks
`else
  localparam logic DBL = 1'b0;  // bank pointers stay on bank 0
`endif

  // COLLECT: bank may be filled; EMIT: bank holds a complete tile not yet fully sent
  typedef enum logic {COLLECT = 1'b0, EMIT = 1'b1} bank_state_t;

  bank_state_t                bank_state      [2];
  bank_state_t                bank_state_next [2];
  logic [N*IN_WIDTH-1:0]      tile_buf        [2][IN_DEPTH];
  logic [IN_WIDTH-1:0]        bank_max        [2];
  logic signed [SHIFT_W-1:0]  bank_shift      [2];

  logic                       wr_bank, rd_bank;
  logic [CNT_W-1:0]           in_cnt, out_cnt;
  logic [IN_WIDTH-1:0]        run_max, beat_max, new_max;
  logic [SHIFT_W-1:0]         msb_idx;
  logic signed [SHIFT_W-1:0]  new_shift;

  logic                       in_hs, in_last, out_hs, out_last_hs;
  logic                       cand, cand_fresh, cand_waiting, load_tile;
  logic [N*IN_WIDTH-1:0]      src_beat;
  logic signed [SHIFT_W-1:0]  src_shift;
  logic [IN_WIDTH-1:0]        src_max;
  logic [N*OUT_WIDTH-1:0]     quant_out;

  // One element: s>0 rounds half up then saturates, s<=0 is an exact left shift
  function automatic logic [OUT_WIDTH-1:0] quant_elem(input logic [IN_WIDTH-1:0] x,
                                                      input logic [SHIFT_W-1:0] s);
    logic signed [IN_WIDTH:0] wide;
    logic signed [IN_WIDTH:0] half;
    logic signed [IN_WIDTH:0] res;
    logic [SHIFT_W-1:0]       amt;
    wide = {x[IN_WIDTH-1], x};
    if (!s[SHIFT_W-1] && (s != '0)) begin
      amt  = s;
      half = WIDE_ONE << (amt - 1'b1);
      res  = (wide + half) >>> amt;
      if (res > QMAX) begin
        res = QMAX;
      end else if (res < QMIN) begin
        res = QMIN;
      end
    end else begin
      amt = -s;
      res = wide <<< amt;
    end
    return OUT_WIDTH'(res);
  endfunction

  function automatic logic [N*OUT_WIDTH-1:0] quant_beat(input logic [N*IN_WIDTH-1:0] beat,
                                                        input logic [SHIFT_W-1:0]    s);
    logic [N*OUT_WIDTH-1:0] q;
    q = '0;
    for (int i = 0; i < N; i++) begin
      q[i*OUT_WIDTH +: OUT_WIDTH] = quant_elem(beat[i*IN_WIDTH +: IN_WIDTH], s);
    end
    return q;
  endfunction

  assign data_in_ready = (bank_state[wr_bank] == COLLECT);
  assign in_hs         = data_in_valid && data_in_ready;
  assign in_last       = in_hs && (in_cnt == LAST_IDX);
  assign out_hs        = data_out_valid && data_out_ready;
  assign out_last_hs   = out_hs && data_out_last;

  // Largest unsigned magnitude in the incoming beat; |-2^(W-1)| stays exact in W bits
  always_comb begin
    logic [IN_WIDTH-1:0] elem;
    logic [IN_WIDTH-1:0] mag;
    beat_max = '0;
    for (int i = 0; i < N; i++) begin
      elem = data_in[i*IN_WIDTH +: IN_WIDTH];
      mag  = elem[IN_WIDTH-1] ? (~elem + 1'b1) : elem;
      if (mag > beat_max) begin
        beat_max = mag;
      end
    end
  end

  assign new_max = (beat_max > run_max) ? beat_max : run_max;

  // Shift that places the tile maximum's MSB just below the output sign bit
  always_comb begin
    msb_idx = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (new_max[i]) begin
        msb_idx = SHIFT_W'(i);
      end
    end
    new_shift = (new_max == '0) ? '0 : (msb_idx - SHIFT_W'(OUT_WIDTH - 2));
  end

  // Next tile to present: the bank after the one just finished, or the current one when idle
  assign cand         = out_last_hs ? (rd_bank ^ DBL) : rd_bank;
  assign cand_fresh   = in_last && (wr_bank == cand);
  assign cand_waiting = (bank_state[cand] == EMIT) && !(out_last_hs && (cand == rd_bank));

  // Select which beat and scale feed the output register this cycle
  always_comb begin
    load_tile = 1'b0;
    src_beat  = tile_buf[rd_bank][out_cnt + 1'b1];
    src_shift = scale_shift;
    src_max   = max_num;
    if (!(out_hs && !data_out_last) && (!data_out_valid || out_last_hs)) begin
      if (cand_fresh) begin
        load_tile = 1'b1;
        src_beat  = (IN_DEPTH == 1) ? data_in : tile_buf[cand][0];
        src_shift = new_shift;
        src_max   = new_max;
      end else if (cand_waiting) begin
        load_tile = 1'b1;
        src_beat  = tile_buf[cand][0];
        src_shift = bank_shift[cand];
        src_max   = bank_max[cand];
      end
    end
  end

  assign quant_out = quant_beat(src_beat, src_shift);

  // Bank occupancy register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++) bank_state[b] <= COLLECT;
    end else begin
      bank_state <= bank_state_next;
    end
  end

  // A bank fills on its last input beat and frees on its last output beat
  always_comb begin
    bank_state_next = bank_state;
    if (in_last) begin
      bank_state_next[wr_bank] = EMIT;
    end
    if (out_last_hs) begin
      bank_state_next[rd_bank] = COLLECT;
    end
  end

  // Tile storage, no reset needed since contents are only read once a tile completes
  always_ff @(posedge clk) begin
    if (in_hs) begin
      tile_buf[wr_bank][in_cnt] <= data_in;
    end
  end

  // Collection side: beat counter, running max and per-bank scale capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_cnt  <= '0;
      wr_bank <= 1'b0;
      run_max <= '0;
      for (int b = 0; b < 2; b++) begin
        bank_max[b]   <= '0;
        bank_shift[b] <= '0;
      end
    end else if (in_hs) begin
      if (in_last) begin
        in_cnt              <= '0;
        run_max             <= '0;
        wr_bank             <= wr_bank ^ DBL;
        bank_max[wr_bank]   <= new_max;
        bank_shift[wr_bank] <= new_shift;
      end else begin
        in_cnt  <= in_cnt + 1'b1;
        run_max <= new_max;
      end
    end
  end

  // Emission side: registered output beat, advanced on handshake, held while stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out       <= '0;
      data_out_valid <= 1'b0;
      data_out_last  <= 1'b0;
      max_num        <= '0;
      scale_shift    <= '0;
      out_cnt        <= '0;
      rd_bank        <= 1'b0;
    end else if (out_hs && !data_out_last) begin
      data_out      <= quant_out;
      data_out_last <= ((out_cnt + 1'b1) == LAST_IDX);
      out_cnt       <= out_cnt + 1'b1;
    end else if (!data_out_valid || out_last_hs) begin
      data_out_valid <= load_tile;
      out_cnt        <= '0;
      if (out_last_hs) begin
        rd_bank <= rd_bank ^ DBL;
      end
      if (load_tile) begin
        data_out      <= quant_out;
        data_out_last <= (IN_DEPTH == 1);
        max_num       <= src_max;
        scale_shift   <= src_shift;
      end else begin
        data_out_last <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fixed_tile_absmax_quantizer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_fixed_tile_absmax_quantizer                                     |
// | Brief  : Scoreboard bench for fixed_tile_absmax_quantizer (single bank).    |
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
module tb_fixed_tile_absmax_quantizer;
  localparam int IW = 16;
  localparam int OW = 8;
  localparam int N  = 4;
  localparam int D  = 3;
  localparam int SW = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [IW*N-1:0]     data_in;
  logic                data_in_valid;
  logic                data_in_ready;
  logic [OW*N-1:0]     data_out;
  logic                data_out_valid;
  logic                data_out_ready;
  logic                data_out_last;
  logic [IW-1:0]       max_num;
  logic signed [SW-1:0] scale_shift;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [OW*N-1:0] d;
    logic            l;
    logic [IW-1:0]   m;
    logic [SW-1:0]   s;
  } exp_t;
  exp_t sb[$];

  fixed_tile_absmax_quantizer #(
    .IN_WIDTH(IW), .IN_SIZE(1), .IN_PARALLELISM(N), .IN_DEPTH(D), .OUT_WIDTH(OW)
  ) dut (
    .clk(clk), .rst(rst),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
    .data_out_last(data_out_last), .max_num(max_num), .scale_shift(scale_shift)
  );

  always #5 clk = ~clk;

  // Reference model: integer arithmetic on the whole tile, pushed before it is sent
  function automatic void push_tile(input logic [IW*N-1:0] t [D]);
    int mx, e, s, v, q, num;
    exp_t x;
    mx = 0;
    for (int b = 0; b < D; b++)
      for (int i = 0; i < N; i++) begin
        v = int'($signed(t[b][i*IW +: IW]));
        if (v < 0) v = -v;
        if (v > mx) mx = v;
      end
    e = -1;
    for (int k = 0; k < IW; k++) if (mx >= (1 << k)) e = k;
    s = (mx == 0) ? 0 : e - (OW - 2);
    for (int b = 0; b < D; b++) begin
      x.d = '0;
      for (int i = 0; i < N; i++) begin
        v = int'($signed(t[b][i*IW +: IW]));
        if (s > 0) begin
          num = v + (1 << (s - 1));
          q = num >>> s;
          if (q > 127) q = 127;
          if (q < -127) q = -127;
        end else begin
          q = v * (1 << (-s));
        end
        x.d[i*OW +: OW] = OW'(q);
      end
      x.l = (b == D - 1);
      x.m = IW'(mx);
      x.s = SW'(s);
      sb.push_back(x);
    end
  endfunction

  // Called just after a negedge; returns just after the negedge following acceptance
  task automatic send_beat(input logic [IW*N-1:0] beat, output bit to);
    int k = 0;
    data_in = beat;
    data_in_valid = 1'b1;
    while (!data_in_ready && k < 50) begin @(negedge clk); k++; end
    to = !data_in_ready;
    @(negedge clk);
    data_in_valid = 1'b0;
  endtask

  task automatic send_tile(input logic [IW*N-1:0] t [D], output bit to);
    bit bt;
    push_tile(t);
    to = 1'b0;
    for (int b = 0; b < D; b++) begin send_beat(t[b], bt); to |= bt; end
  endtask

  task automatic recv_beat(output logic [OW*N-1:0] d, output logic l, output logic [IW-1:0] m,
                           output logic [SW-1:0] s, output bit to);
    int k = 0;
    data_out_ready = 1'b1;
    while (!data_out_valid && k < 50) begin @(negedge clk); k++; end
    to = !data_out_valid;
    d = data_out; l = data_out_last; m = max_num; s = scale_shift;
    @(negedge clk);
    data_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    data_in = '0; data_in_valid = 1'b0; data_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({data_out_valid, data_out_last, data_out, max_num, scale_shift, data_in_ready} !==
        {1'b0, 1'b0, 32'h0, 16'h0, 5'h0, 1'b1})
      $display("FAIL reset got v=%b l=%b d=%h m=%h s=%h rdy=%b want 0 0 0 0 0 1",
               data_out_valid, data_out_last, data_out, max_num, scale_shift, data_in_ready);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_saturation();
    logic [IW*N-1:0] t [D];
    logic [OW*N-1:0] d; logic l; logic [IW-1:0] m; logic [SW-1:0] s; bit to;
    exp_t ex;
    t[0] = {16'h0010, 16'hFFF0, 16'h0180, 16'h7FFF};
    t[1] = {16'h1234, 16'hEDCC, 16'h0000, 16'h0001};
    t[2] = {16'h8001, 16'h00FF, 16'h4000, 16'hC000};
    send_tile(t, to);
    total++;
    if (to) $display("FAIL sat_send timeout ready=%b want 1", data_in_ready); else passed++;
    for (int b = 0; b < D; b++) begin
      recv_beat(d, l, m, s, to);
      ex = sb.pop_front();
      total++;
      if (to || {d, l, m, s} !== {ex.d, ex.l, ex.m, ex.s})
        $display("FAIL sat_beat%0d got d=%h l=%b m=%h s=%h want d=%h l=%b m=%h s=%h",
                 b, d, l, m, s, ex.d, ex.l, ex.m, ex.s);
      else passed++;
      if (b == 0) begin
        total++;
        if ({d[15:0], m, s} !== {8'h02, 8'h7F, 16'h7FFF, 5'd8})
          $display("FAIL sat_spot got e1e0=%h m=%h s=%h want 027f 7fff 08", d[15:0], m, s);
        else passed++;
      end
    end
  endtask

  task automatic test_zero_tile();
    logic [IW*N-1:0] t [D];
    logic [OW*N-1:0] d; logic l; logic [IW-1:0] m; logic [SW-1:0] s; bit to;
    exp_t ex;
    for (int b = 0; b < D; b++) t[b] = '0;
    send_tile(t, to);
    for (int b = 0; b < D; b++) begin
      recv_beat(d, l, m, s, to);
      ex = sb.pop_front();
      total++;
      if (to || {d, l, m, s} !== {ex.d, ex.l, ex.m, ex.s} || {d, m, s} !== '0 || l !== (b == D - 1))
        $display("FAIL zero_beat%0d got d=%h l=%b m=%h s=%h want d=%h l=%b m=%h s=%h",
                 b, d, l, m, s, ex.d, ex.l, ex.m, ex.s);
      else passed++;
    end
  endtask

  task automatic test_min_negative();
    logic [IW*N-1:0] t [D];
    logic [OW*N-1:0] d; logic l; logic [IW-1:0] m; logic [SW-1:0] s; bit to;
    exp_t ex;
    bit saw80;
    t[0] = {16'h0005, 16'hFFFB, 16'h0100, 16'h0000};
    t[1] = {16'h0001, 16'h8000, 16'h0002, 16'hFF00};
    t[2] = {16'h0300, 16'h0000, 16'hFD00, 16'h0007};
    send_tile(t, to);
    saw80 = 1'b0;
    for (int b = 0; b < D; b++) begin
      recv_beat(d, l, m, s, to);
      ex = sb.pop_front();
      for (int i = 0; i < N; i++) if (d[i*OW +: OW] == 8'h80) saw80 = 1'b1;
      total++;
      if (to || {d, l, m, s} !== {ex.d, ex.l, ex.m, ex.s})
        $display("FAIL minneg_beat%0d got d=%h l=%b m=%h s=%h want d=%h l=%b m=%h s=%h",
                 b, d, l, m, s, ex.d, ex.l, ex.m, ex.s);
      else passed++;
      if (b == 1) begin
        total++;
        if ({d[23:16], m, s} !== {8'hC0, 16'h8000, 5'd9})
          $display("FAIL minneg_spot got e2=%h m=%h s=%h want c0 8000 09", d[23:16], m, s);
        else passed++;
      end
    end
    total++;
    if (saw80) $display("FAIL minneg_no_m128 got 80 emitted want none"); else passed++;
  endtask

  task automatic test_small_max();
    logic [IW*N-1:0] t [D];
    logic [OW*N-1:0] d; logic l; logic [IW-1:0] m; logic [SW-1:0] s; bit to;
    exp_t ex;
    t[0] = {16'h0000, 16'hFFFD, 16'h0001, 16'h0015};
    t[1] = {16'h000A, 16'hFFF0, 16'h0002, 16'hFFEB};
    t[2] = {16'h0014, 16'h0003, 16'hFFFF, 16'h0000};
    send_tile(t, to);
    for (int b = 0; b < D; b++) begin
      recv_beat(d, l, m, s, to);
      ex = sb.pop_front();
      total++;
      if (to || {d, l, m, s} !== {ex.d, ex.l, ex.m, ex.s})
        $display("FAIL small_beat%0d got d=%h l=%b m=%h s=%h want d=%h l=%b m=%h s=%h",
                 b, d, l, m, s, ex.d, ex.l, ex.m, ex.s);
      else passed++;
      if (b == 0) begin
        total++;
        if ({d[23:16], d[7:0], m, s} !== {8'hF4, 8'h54, 16'h0015, 5'h1E})
          $display("FAIL small_spot got e2=%h e0=%h m=%h s=%h want f4 54 0015 1e",
                   d[23:16], d[7:0], m, s);
        else passed++;
      end
    end
  endtask

  task automatic test_stall();
    logic [IW*N-1:0] t [D];
    logic [OW*N-1:0] d; logic l; logic [IW-1:0] m; logic [SW-1:0] s; bit to;
    exp_t ex;
    t[0] = {16'h0123, 16'hF00D, 16'h0777, 16'h1000};
    t[1] = {16'hFEDC, 16'h0042, 16'h2222, 16'hE000};
    t[2] = {16'h0001, 16'hFFFF, 16'h0F0F, 16'h3FFF};
    send_tile(t, to);
    for (int b = 0; b < D; b++) begin
      recv_beat(d, l, m, s, to);
      ex = sb.pop_front();
      total++;
      if (to || {d, l, m, s} !== {ex.d, ex.l, ex.m, ex.s})
        $display("FAIL stall_beat%0d got d=%h l=%b m=%h s=%h want d=%h l=%b m=%h s=%h",
                 b, d, l, m, s, ex.d, ex.l, ex.m, ex.s);
      else passed++;
      if (b == 0) begin
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          total++;
          if ({data_out_valid, data_in_ready, data_out, data_out_last, max_num, scale_shift} !==
              {1'b1, 1'b0, sb[0].d, sb[0].l, sb[0].m, sb[0].s})
            $display("FAIL stall_hold%0d got v=%b rdy=%b d=%h l=%b m=%h s=%h want 1 0 %h %b %h %h",
                     c, data_out_valid, data_in_ready, data_out, data_out_last, max_num,
                     scale_shift, sb[0].d, sb[0].l, sb[0].m, sb[0].s);
          else passed++;
        end
      end
    end
  endtask

  task automatic test_reset_mid_tile();
    logic [IW*N-1:0] t [D];
    logic [OW*N-1:0] d; logic l; logic [IW-1:0] m; logic [SW-1:0] s; bit to;
    exp_t ex;
    send_beat({16'h7FFF, 16'h8000, 16'h7000, 16'h6000}, to);
    send_beat({16'h5000, 16'h4000, 16'h3000, 16'h2000}, to);
    rst = 1'b0;
    #1;
    total++;
    if ({data_out_valid, data_out_last, data_out, max_num, scale_shift, data_in_ready} !==
        {1'b0, 1'b0, 32'h0, 16'h0, 5'h0, 1'b1})
      $display("FAIL midrst got v=%b l=%b d=%h m=%h s=%h rdy=%b want 0 0 0 0 0 1",
               data_out_valid, data_out_last, data_out, max_num, scale_shift, data_in_ready);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (data_out_valid !== 1'b0) $display("FAIL midrst_idle got v=%b want 0", data_out_valid);
    else passed++;
    t[0] = {16'h0001, 16'hFFFE, 16'h0000, 16'h0003};
    t[1] = {16'h0002, 16'h0000, 16'hFFFD, 16'h0001};
    t[2] = {16'h0000, 16'h0001, 16'h0002, 16'hFFFF};
    send_tile(t, to);
    for (int b = 0; b < D; b++) begin
      recv_beat(d, l, m, s, to);
      ex = sb.pop_front();
      total++;
      if (to || {d, l, m, s} !== {ex.d, ex.l, ex.m, ex.s})
        $display("FAIL midrst_beat%0d got d=%h l=%b m=%h s=%h want d=%h l=%b m=%h s=%h",
                 b, d, l, m, s, ex.d, ex.l, ex.m, ex.s);
      else passed++;
      if (b == 0) begin
        total++;
        if ({d[7:0], m, s} !== {8'h60, 16'h0003, 5'h1B})
          $display("FAIL midrst_spot got e0=%h m=%h s=%h want 60 0003 1b", d[7:0], m, s);
        else passed++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [IW*N-1:0] t_a [D];
    logic [IW*N-1:0] t_b [D];
    logic [OW*N-1:0] d; logic l; logic [IW-1:0] m; logic [SW-1:0] s; bit to, to_a, to_b;
    logic [IW-1:0] r;
    exp_t ex;
    for (int b = 0; b < D; b++)
      for (int i = 0; i < N; i++) begin
        r = 16'($urandom);
        t_a[b][i*IW +: IW] = 16'($signed(r) >>> $urandom_range(0, 14));
        r = 16'($urandom);
        t_b[b][i*IW +: IW] = 16'($signed(r) >>> $urandom_range(4, 15));
      end
    fork
      begin
        send_tile(t_a, to_a);
        send_tile(t_b, to_b);
      end
      begin
        for (int k = 0; k < 2 * D; k++) begin
          recv_beat(d, l, m, s, to);
          ex = sb.pop_front();
          total++;
          if (to || {d, l, m, s} !== {ex.d, ex.l, ex.m, ex.s})
            $display("FAIL b2b_beat%0d got d=%h l=%b m=%h s=%h want d=%h l=%b m=%h s=%h",
                     k, d, l, m, s, ex.d, ex.l, ex.m, ex.s);
          else passed++;
        end
      end
    join
    total++;
    if (to_a || to_b) $display("FAIL b2b_send timeout got %b%b want 00", to_a, to_b);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_saturation();
    test_zero_tile();
    test_min_negative();
    test_small_max();
    test_stall();
    test_reset_mid_tile();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
